serial_mag_comparator: RTL and testbench



---
 rtl/serial_mag_comparator.sv | 135 +++++++++++++
 tb/tb_serial_mag_comparator.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/serial_mag_comparator.sv
// Digit-serial magnitude comparator: compares two WIDTH-bit operands DIGIT bits
// per clock, MSB digit first, and keeps a saturating count of equal results.
module serial_mag_comparator #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  logic             signed_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  logic             clr_count_i,
  output logic             busy_o,
  output logic             done_o,
  output logic             eq_o,
  output logic             lt_o,
  output logic             gt_o,
  output logic [CNT_W-1:0] eq_count_o
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? $clog2(N) : 1;
  localparam logic [WIDTH-1:0] MSB_MASK = WIDTH'(1) << (WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d, b_sh_q, b_sh_d;
  logic [CW-1:0]    dig_cnt_q, dig_cnt_d;
  logic             undec_q, undec_d;
  logic             lt_acc_q, lt_acc_d, gt_acc_q, gt_acc_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             eq_q, eq_d, lt_q, lt_d, gt_q, gt_d;
  logic [CNT_W-1:0] eq_count_q, eq_count_d;

  logic [DIGIT-1:0] dig_a, dig_b;
  assign dig_a = a_sh_q[WIDTH-1 -: DIGIT];
  assign dig_b = b_sh_q[WIDTH-1 -: DIGIT];

  always_comb begin
    state_d    = state_q;
    a_sh_d     = a_sh_q;
    b_sh_d     = b_sh_q;
    dig_cnt_d  = dig_cnt_q;
    undec_d    = undec_q;
    lt_acc_d   = lt_acc_q;
    gt_acc_d   = gt_acc_q;
    done_d     = 1'b0;
    eq_d       = eq_q;
    lt_d       = lt_q;
    gt_d       = gt_q;
    eq_count_d = eq_count_q;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          // Offset-binary: flipping both MSBs turns a signed compare into unsigned.
          a_sh_d    = signed_i ? (a_i ^ MSB_MASK) : a_i;
          b_sh_d    = signed_i ? (b_i ^ MSB_MASK) : b_i;
          dig_cnt_d = CW'(N - 1);
          undec_d   = 1'b1;
          lt_acc_d  = 1'b0;
          gt_acc_d  = 1'b0;
          state_d   = RUN;
        end
      end
      RUN: begin
        if (undec_q && (dig_a != dig_b)) begin
          undec_d  = 1'b0;
          lt_acc_d = (dig_a < dig_b);
          gt_acc_d = (dig_a > dig_b);
        end
        a_sh_d    = a_sh_q << DIGIT;
        b_sh_d    = b_sh_q << DIGIT;
        dig_cnt_d = dig_cnt_q - CW'(1);
        if (dig_cnt_q == '0) state_d = DONE;
      end
      DONE: begin
        done_d  = 1'b1;
        eq_d    = undec_q;
        lt_d    = lt_acc_q;
        gt_d    = gt_acc_q;
        if (undec_q && (eq_count_q != CNT_MAX)) eq_count_d = eq_count_q + CNT_W'(1);
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    if (clr_count_i) eq_count_d = '0;
    busy_d = (state_d == RUN);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      a_sh_q     <= '0;
      b_sh_q     <= '0;
      dig_cnt_q  <= '0;
      undec_q    <= 1'b0;
      lt_acc_q   <= 1'b0;
      gt_acc_q   <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      eq_q       <= 1'b0;
      lt_q       <= 1'b0;
      gt_q       <= 1'b0;
      eq_count_q <= '0;
    end else begin
      state_q    <= state_d;
      a_sh_q     <= a_sh_d;
      b_sh_q     <= b_sh_d;
      dig_cnt_q  <= dig_cnt_d;
      undec_q    <= undec_d;
      lt_acc_q   <= lt_acc_d;
      gt_acc_q   <= gt_acc_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      eq_q       <= eq_d;
      lt_q       <= lt_d;
      gt_q       <= gt_d;
      eq_count_q <= eq_count_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign eq_o       = eq_q;
  assign lt_o       = lt_q;
  assign gt_o       = gt_q;
  assign eq_count_o = eq_count_q;

endmodule

// File: tb/tb_serial_mag_comparator.sv
// Directed, table-driven bench for serial_mag_comparator: a default instance,
// a CNT_W=2 instance for saturation and a DIGIT=WIDTH instance, all on shared inputs.
module tb_serial_mag_comparator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start_i, signed_i, clr_count_i;
  logic [15:0] a_i, b_i;

  logic       busy_o, done_o, eq_o, lt_o, gt_o;
  logic [7:0] eq_count_o;
  logic       s_busy, s_done, s_eq, s_lt, s_gt;
  logic [1:0] s_count;
  logic       n_busy, n_done, n_eq, n_lt, n_gt;
  logic [7:0] n_count;

  int n_vec = 0;
  int n_err = 0;
  int exp_cnt = 0, exp_sat = 0, exp_n1 = 0;

  always #5 clk = ~clk;

  serial_mag_comparator dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .clr_count_i(clr_count_i),
    .busy_o(busy_o), .done_o(done_o), .eq_o(eq_o), .lt_o(lt_o), .gt_o(gt_o),
    .eq_count_o(eq_count_o)
  );

  serial_mag_comparator #(.CNT_W(2)) dut_sat (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .clr_count_i(clr_count_i),
    .busy_o(s_busy), .done_o(s_done), .eq_o(s_eq), .lt_o(s_lt), .gt_o(s_gt),
    .eq_count_o(s_count)
  );

  serial_mag_comparator #(.DIGIT(16)) dut_n1 (
    .clk(clk), .rst_n(rst_n), .start_i(start_i), .signed_i(signed_i),
    .a_i(a_i), .b_i(b_i), .clr_count_i(clr_count_i),
    .busy_o(n_busy), .done_o(n_done), .eq_o(n_eq), .lt_o(n_lt), .gt_o(n_gt),
    .eq_count_o(n_count)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic        s;
    logic        eq;
    logic        lt;
    logic        gt;
  } vec_t;

  vec_t tbl[10];

  task automatic chk(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic bump_counts(input logic eq_main, input logic eq_n1);
    if (eq_main) begin
      if (exp_cnt < 255) exp_cnt++;
      if (exp_sat < 3) exp_sat++;
    end
    if (eq_n1 && exp_n1 < 255) exp_n1++;
  endtask

  task automatic chk_counts(input string tag);
    chk({tag, "_count"}, eq_count_o, exp_cnt);
    chk({tag, "_sat_count"}, s_count, exp_sat);
    chk({tag, "_n1_count"}, n_count, exp_n1);
  endtask

  // mode 0: plain, 1: clr_count_i aligned with DONE, 2: start/a_i poke mid-RUN,
  // 3: reset mid-RUN. lat = edges from start sample to done_o, -1 if never.
  task automatic run_cmp(input logic [15:0] a, input logic [15:0] b, input logic s,
                         input int mode, output int lat, output int busy_n);
    int k;
    @(negedge clk);
    a_i = a; b_i = b; signed_i = s; start_i = 1'b1;
    @(posedge clk);
    k = 0; lat = -1; busy_n = 0;
    @(negedge clk);
    start_i = 1'b0;
    while (k < 12 && lat < 0) begin
      if (busy_o) busy_n++;
      if (done_o) lat = k;
      if (mode != 2 && k == 1) begin
        a_i = 16'($urandom); b_i = 16'($urandom); signed_i = 1'($urandom);
      end
      if (mode == 1 && k == 4) clr_count_i = 1'b1;
      if (mode == 1 && k == 5) clr_count_i = 1'b0;
      if (mode == 2 && k == 2) begin start_i = 1'b1; a_i = b; end
      if (mode == 2 && k == 3) start_i = 1'b0;
      if (mode == 3 && k == 2) begin
        rst_n = 1'b0;
        #1;
        break;
      end
      if (lat < 0) begin
        @(posedge clk);
        k++;
        @(negedge clk);
      end
    end
    clr_count_i = 1'b0;
  endtask

  initial begin
    int lat, bn, seen;

    tbl[0] = '{16'h1234, 16'h1234, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{16'h8000, 16'h7FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[2] = '{16'h8000, 16'h7FFF, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[4] = '{16'h1000, 16'h0FFF, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{16'h0010, 16'h0011, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[6] = '{16'h7FFF, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{16'hFFFF, 16'hFFFF, 1'b1, 1'b1, 1'b0, 1'b0};
    tbl[8] = '{16'h0000, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0};
    tbl[9] = '{16'h8001, 16'h8000, 1'b1, 1'b0, 1'b0, 1'b1};

    // Reset with start held high
    rst_n = 1'b0; start_i = 1'b1; signed_i = 1'b0; clr_count_i = 1'b0;
    a_i = 16'h1111; b_i = 16'h2222;
    repeat (3) @(negedge clk);
    chk("rst_busy", busy_o, 0);
    chk("rst_done", done_o, 0);
    chk("rst_flags", {eq_o, lt_o, gt_o}, 0);
    chk_counts("rst");
    start_i = 1'b0;
    rst_n = 1'b1;
    seen = 0;
    repeat (3) begin
      @(negedge clk);
      if (busy_o || done_o) seen++;
    end
    chk("idle_quiet", seen, 0);

    // Table-driven compares
    for (int i = 0; i < 10; i++) begin
      run_cmp(tbl[i].a, tbl[i].b, tbl[i].s, 0, lat, bn);
      bump_counts(tbl[i].eq, tbl[i].eq);
      chk($sformatf("v%0d_latency", i), lat, 5);
      chk($sformatf("v%0d_busy_cycles", i), bn, 4);
      chk($sformatf("v%0d_eq", i), eq_o, tbl[i].eq);
      chk($sformatf("v%0d_lt", i), lt_o, tbl[i].lt);
      chk($sformatf("v%0d_gt", i), gt_o, tbl[i].gt);
      chk($sformatf("v%0d_n1_flags", i), {n_eq, n_lt, n_gt}, {tbl[i].eq, tbl[i].lt, tbl[i].gt});
      chk_counts($sformatf("v%0d", i));
      @(negedge clk);
      chk($sformatf("v%0d_done_width", i), done_o, 0);
    end

    // start_i and a_i poked mid-RUN: ignored by the 4-digit units; the
    // single-digit unit is idle by then and takes it as a new equal compare.
    run_cmp(16'h1000, 16'h0FFF, 1'b0, 2, lat, bn);
    bump_counts(1'b0, 1'b1);
    chk("iso_latency", lat, 5);
    chk("iso_flags", {eq_o, lt_o, gt_o}, 3'b001);
    chk("iso_n1_flags", {n_eq, n_lt, n_gt}, 3'b100);
    chk_counts("iso");
    seen = 0;
    repeat (4) begin
      @(negedge clk);
      if (done_o) seen++;
    end
    chk("iso_extra_done", seen, 0);
    chk("iso_persist", {eq_o, lt_o, gt_o, busy_o}, 4'b0010);

    // Clear, then saturate the CNT_W=2 counter
    @(negedge clk);
    clr_count_i = 1'b1;
    @(negedge clk);
    clr_count_i = 1'b0;
    exp_cnt = 0; exp_sat = 0; exp_n1 = 0;
    chk_counts("clr");
    for (int i = 0; i < 5; i++) begin
      run_cmp(16'hABCD, 16'hABCD, 1'(i), 0, lat, bn);
      bump_counts(1'b1, 1'b1);
    end
    chk("sat_eq", eq_o, 1);
    chk_counts("sat");

    // clr_count_i in the same cycle as an equal DONE
    run_cmp(16'h5A5A, 16'h5A5A, 1'b0, 1, lat, bn);
    exp_cnt = 0; exp_sat = 0; exp_n1 = 0;
    chk("clrdone_latency", lat, 5);
    chk("clrdone_eq", eq_o, 1);
    chk_counts("clrdone");

    // Reset mid-RUN after one equal result has been recorded
    run_cmp(16'h0042, 16'h0042, 1'b0, 0, lat, bn);
    bump_counts(1'b1, 1'b1);
    chk_counts("prerst");
    run_cmp(16'h9000, 16'h1000, 1'b0, 3, lat, bn);
    exp_cnt = 0; exp_sat = 0; exp_n1 = 0;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_done", done_o, 0);
    chk("midrst_flags", {eq_o, lt_o, gt_o}, 0);
    chk_counts("midrst");
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (8) begin
      @(negedge clk);
      if (done_o || busy_o) seen++;
    end
    chk("midrst_abandoned", seen, 0);
    run_cmp(16'h0001, 16'h0002, 1'b0, 0, lat, bn);
    chk("postrst_latency", lat, 5);
    chk("postrst_flags", {eq_o, lt_o, gt_o}, 3'b010);
    chk_counts("postrst");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
